// File: rtl/seq_tx_arbiter_if.sv
// Bundle between the requesters, the round-robin arbiter and the shared serial transmitter.
// The slave modport is the arbiter's view; the master modport drives requests and the transmitter's done flag.
interface seq_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 10
);
  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*WORD_W-1:0] i_data;
  logic [NUM_REQ-1:0]        o_grant;
  logic [NUM_REQ-1:0]        o_done;
  logic                      o_err;
  logic [OWN_W-1:0]          o_owner;
  logic                      o_busy;
  logic                      o_tx_load;
  logic [WORD_W-1:0]         o_tx_word;
  logic                      i_tx_done;

  modport slave (
    input  i_req, i_data, i_tx_done,
    output o_grant, o_done, o_err, o_owner, o_busy, o_tx_load, o_tx_word
  );

  modport master (
    output i_req, i_data, i_tx_done,
    input  o_grant, o_done, o_err, o_owner, o_busy, o_tx_load, o_tx_word
  );
endinterface

// File: rtl/seq_tx_arbiter.sv
// Round-robin scheduler sharing one serial transmitter between NUM_REQ word sources,
// with a watchdog on each transfer and an optional idle gap between words.
module seq_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_W     = 10,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 15
) (
  input logic             i_clk,
  input logic             i_reset,
  seq_tx_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [PTR_W-1:0]   owner, owner_n;
  logic [WORD_W-1:0]  word, word_n;
  logic [WD_W-1:0]    wdog, wdog_n, wdog_inc;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic [NUM_REQ-1:0] grant, grant_n;
  logic [NUM_REQ-1:0] done, done_n;
  logic               err, err_n;
  logic               busy, busy_n;
  logic               load, load_n;
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W:0]     sum;
  logic               xfer_end;

  // Every output is computed one cycle ahead and registered, so nothing reaches an output combinationally.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    owner_n  = owner;
    word_n   = word;
    wdog_n   = wdog;
    gap_n    = gap_cnt;
    grant_n  = '0;
    done_n   = '0;
    err_n    = 1'b0;
    load_n   = 1'b0;
    found    = 1'b0;
    win      = '0;
    sum      = '0;
    xfer_end = 1'b0;
    wdog_inc = (wdog == WD_W'(TIMEOUT)) ? wdog : wdog + 1'b1;

    case (state)
      IDLE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          sum = {1'b0, ptr} + (PTR_W+1)'(i);
          if (sum >= (PTR_W+1)'(NUM_REQ))
            sum = sum - (PTR_W+1)'(NUM_REQ);
          if (!found && bus.i_req[sum[PTR_W-1:0]]) begin
            found = 1'b1;
            win   = sum[PTR_W-1:0];
          end
        end
        if (found) begin
          word_n  = bus.i_data[win*WORD_W +: WORD_W];
          owner_n = win;
          ptr_n   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          grant_n = NUM_REQ'(1) << win;
          load_n  = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        wdog_n  = '0;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        wdog_n = wdog_inc;
        // A done arriving on the timeout cycle still counts as a clean completion.
        if (bus.i_tx_done) begin
          done_n   = NUM_REQ'(1) << owner;
          xfer_end = 1'b1;
        end else if (wdog_inc == WD_W'(TIMEOUT)) begin
          err_n    = 1'b1;
          xfer_end = 1'b1;
        end
        if (xfer_end) begin
          gap_n   = '0;
          state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1))
          state_n = IDLE;
        else
          gap_n = gap_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      word    <= '0;
      wdog    <= '0;
      gap_cnt <= '0;
      grant   <= '0;
      done    <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      load    <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      word    <= word_n;
      wdog    <= wdog_n;
      gap_cnt <= gap_n;
      grant   <= grant_n;
      done    <= done_n;
      err     <= err_n;
      busy    <= busy_n;
      load    <= load_n;
    end
  end

  assign bus.o_grant   = grant;
  assign bus.o_done    = done;
  assign bus.o_err     = err;
  assign bus.o_owner   = owner;
  assign bus.o_busy    = busy;
  assign bus.o_tx_load = load;
  assign bus.o_tx_word = word;
endmodule

// File: tb/tb_seq_tx_arbiter.sv
// Scoreboard bench for seq_tx_arbiter: directed requests push expected grant/done/err events,
// a monitor pops them as the DUT emits them; a small model stands in for the transmitter.
module tb_seq_tx_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int WORD_W     = 10;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 15;

  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int         kind;
    logic [3:0] vec;
    logic [9:0] word;
    int         idx;
    int         lag;
  } exp_t;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  logic model_done = 1'b0;
  logic spur_done  = 1'b0;
  bit   started    = 1'b0;
  int   tx_delay   = 10;
  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  exp_t exp_q[$];

  seq_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) bus ();

  seq_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .WORD_W(WORD_W),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .bus(bus)
  );

  assign bus.i_tx_done = model_done | spur_done;

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  function automatic void pushExp(input int kind, input int idx, input logic [9:0] word, input int lag);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.vec  = (kind == K_ERR) ? 4'b0000 : (4'b0001 << idx);
    e.word = word;
    e.lag  = lag;
    exp_q.push_back(e);
  endfunction

  task automatic applyStimulus(input logic [3:0] mask, input logic [9:0] w0, input logic [9:0] w1,
                               input logic [9:0] w2, input logic [9:0] w3);
    bus.i_req  = mask;
    bus.i_data = {w3, w2, w1, w0};
  endtask

  task automatic waitQueue(input int n, input int budget);
    int k = 0;
    while (exp_q.size() > n && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    if (exp_q.size() > n) begin
      checkOutput("event_timeout", 32'(exp_q.size()), 32'(n));
      exp_q.delete();
    end
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || bus.o_busy !== 1'b0) && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    checkOutput("idle_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("idle_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic waitDone(input int budget);
    int k = 0;
    while (bus.o_done === 4'b0000 && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    checkOutput("done_seen", 32'(bus.o_done !== 4'b0000), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"},   32'(bus.o_grant),   32'd0);
    checkOutput({tag, "_done"},    32'(bus.o_done),    32'd0);
    checkOutput({tag, "_err"},     32'(bus.o_err),     32'd0);
    checkOutput({tag, "_owner"},   32'(bus.o_owner),   32'd0);
    checkOutput({tag, "_busy"},    32'(bus.o_busy),    32'd0);
    checkOutput({tag, "_tx_load"}, 32'(bus.o_tx_load), 32'd0);
    checkOutput({tag, "_tx_word"}, 32'(bus.o_tx_word), 32'd0);
  endtask

  // Transmitter stand-in: answers each load with a one-cycle done after tx_delay cycles (0 = never).
  initial begin : tx_model
    int d;
    forever begin
      @(negedge i_clk);
      if (bus.o_tx_load === 1'b1 && i_reset === 1'b0) begin
        d = tx_delay;
        if (d > 0) begin
          repeat (d) @(negedge i_clk);
          model_done = 1'b1;
          @(negedge i_clk);
          model_done = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    int   last_load;
    exp_t e;
    last_load = 0;
    wait (started);
    forever begin
      @(negedge i_clk);
      if (bus.o_tx_load === 1'b1 || bus.o_grant !== 4'b0000 || bus.o_done !== 4'b0000 || bus.o_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_event", 32'({bus.o_tx_load, bus.o_err, bus.o_done, bus.o_grant}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          case (e.kind)
            K_GRANT: begin
              checkOutput("grant", 32'(bus.o_grant), 32'(e.vec));
              checkOutput("tx_load", 32'(bus.o_tx_load), 32'd1);
              checkOutput("tx_word", 32'(bus.o_tx_word), 32'(e.word));
              checkOutput("owner", 32'(bus.o_owner), 32'(e.idx));
              checkOutput("busy_in_load", 32'(bus.o_busy), 32'd1);
              last_load = cyc;
            end
            K_DONE: begin
              checkOutput("done", 32'(bus.o_done), 32'(e.vec));
              checkOutput("no_err_on_done", 32'(bus.o_err), 32'd0);
              checkOutput("done_lag", 32'(cyc - last_load), 32'(e.lag));
            end
            default: begin
              checkOutput("err", 32'(bus.o_err), 32'd1);
              checkOutput("no_done_on_err", 32'(bus.o_done), 32'd0);
              checkOutput("err_lag", 32'(cyc - last_load), 32'(e.lag));
            end
          endcase
        end
      end
    end
  end

  initial begin : stimulus
    applyStimulus(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0);
    repeat (3) @(negedge i_clk);
    checkAllZero("reset");
    started = 1'b1;
    i_reset = 1'b0;

    // Spurious done while idle
    @(negedge i_clk);
    spur_done = 1'b1;
    @(negedge i_clk);
    spur_done = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("spurious_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("spurious_grant", 32'(bus.o_grant), 32'd0);

    // Single requester, then busy drops after the two gap cycles
    tx_delay = 10;
    pushExp(K_GRANT, 0, 10'h2A5, 0);
    pushExp(K_DONE, 0, 10'h0, 11);
    applyStimulus(4'b0001, 10'h2A5, 10'h0, 10'h0, 10'h0);
    waitQueue(1, 40);
    bus.i_req = 4'b0000;
    waitDone(40);
    @(negedge i_clk);
    checkOutput("gap_busy", 32'(bus.o_busy), 32'd1);
    @(negedge i_clk);
    checkOutput("post_gap_busy", 32'(bus.o_busy), 32'd0);
    waitIdle(40);

    // Watchdog: transmitter never answers
    tx_delay = 0;
    pushExp(K_GRANT, 2, 10'h155, 0);
    pushExp(K_ERR, 2, 10'h0, TIMEOUT + 1);
    applyStimulus(4'b0100, 10'h0, 10'h0, 10'h155, 10'h0);
    waitQueue(1, 40);
    bus.i_req = 4'b0000;
    waitIdle(60);

    // Served normally after the abort; pointer is 3 so requester 0 wins via wrap
    tx_delay = 10;
    pushExp(K_GRANT, 0, 10'h0F0, 0);
    pushExp(K_DONE, 0, 10'h0, 11);
    applyStimulus(4'b0001, 10'h0F0, 10'h0, 10'h0, 10'h0);
    waitQueue(1, 40);
    bus.i_req = 4'b0000;
    waitIdle(60);

    // Done on the exact timeout cycle wins
    tx_delay = TIMEOUT;
    pushExp(K_GRANT, 1, 10'h3C3, 0);
    pushExp(K_DONE, 1, 10'h0, TIMEOUT + 1);
    applyStimulus(4'b0010, 10'h0, 10'h3C3, 10'h0, 10'h0);
    waitQueue(1, 40);
    bus.i_req = 4'b0000;
    waitIdle(60);

    // Done one cycle late: abort, and the late done lands in GAP and is ignored
    tx_delay = TIMEOUT + 1;
    pushExp(K_GRANT, 3, 10'h111, 0);
    pushExp(K_ERR, 3, 10'h0, TIMEOUT + 1);
    applyStimulus(4'b1000, 10'h0, 10'h0, 10'h0, 10'h111);
    waitQueue(1, 40);
    bus.i_req = 4'b0000;
    waitIdle(60);

    // Pointer at 0 after grant to 3: 1010 grants 1 then 3
    tx_delay = 10;
    pushExp(K_GRANT, 1, 10'h0AA, 0);
    pushExp(K_DONE, 1, 10'h0, 11);
    pushExp(K_GRANT, 3, 10'h255, 0);
    pushExp(K_DONE, 3, 10'h0, 11);
    applyStimulus(4'b1010, 10'h0, 10'h0AA, 10'h0, 10'h255);
    waitQueue(1, 80);
    bus.i_req = 4'b0000;
    waitIdle(60);

    // Grant 2 moves pointer to 3; 1011 then wraps 3, 0, 1
    pushExp(K_GRANT, 2, 10'h133, 0);
    pushExp(K_DONE, 2, 10'h0, 11);
    applyStimulus(4'b0100, 10'h0, 10'h0, 10'h133, 10'h0);
    waitQueue(1, 40);
    bus.i_req = 4'b0000;
    waitIdle(60);
    pushExp(K_GRANT, 3, 10'h3F0, 0);
    pushExp(K_DONE, 3, 10'h0, 11);
    pushExp(K_GRANT, 0, 10'h301, 0);
    pushExp(K_DONE, 0, 10'h0, 11);
    pushExp(K_GRANT, 1, 10'h012, 0);
    pushExp(K_DONE, 1, 10'h0, 11);
    applyStimulus(4'b1011, 10'h301, 10'h012, 10'h0, 10'h3F0);
    waitQueue(1, 120);
    bus.i_req = 4'b0000;
    waitIdle(60);

    // Reset mid-transfer: no done for the aborted word, late transmitter done ignored
    pushExp(K_GRANT, 2, 10'h1E1, 0);
    applyStimulus(4'b0100, 10'h0, 10'h0, 10'h1E1, 10'h0);
    waitQueue(0, 40);
    bus.i_req = 4'b0000;
    repeat (4) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    checkAllZero("midreset");
    repeat (15) @(negedge i_clk);
    checkOutput("after_reset_busy", 32'(bus.o_busy), 32'd0);

    // Round robin with all requests held, pointer restarted at 0
    pushExp(K_GRANT, 0, 10'h001, 0);
    pushExp(K_DONE, 0, 10'h0, 11);
    pushExp(K_GRANT, 1, 10'h002, 0);
    pushExp(K_DONE, 1, 10'h0, 11);
    pushExp(K_GRANT, 2, 10'h004, 0);
    pushExp(K_DONE, 2, 10'h0, 11);
    pushExp(K_GRANT, 3, 10'h008, 0);
    pushExp(K_DONE, 3, 10'h0, 11);
    pushExp(K_GRANT, 0, 10'h001, 0);
    pushExp(K_DONE, 0, 10'h0, 11);
    pushExp(K_GRANT, 1, 10'h002, 0);
    pushExp(K_DONE, 1, 10'h0, 11);
    pushExp(K_GRANT, 2, 10'h004, 0);
    pushExp(K_DONE, 2, 10'h0, 11);
    pushExp(K_GRANT, 3, 10'h008, 0);
    pushExp(K_DONE, 3, 10'h0, 11);
    applyStimulus(4'b1111, 10'h001, 10'h002, 10'h004, 10'h008);
    waitQueue(1, 300);
    bus.i_req = 4'b0000;
    waitIdle(80);

    repeat (5) @(negedge i_clk);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : global_guard
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "[TB] global timeout");
  end
endmodule
